// File: rtl/tx_frame_scheduler.sv
// Periodic ADC sampler that frames each sample as HEADER, sample, seq, chk and
// feeds the bytes one at a time to a UART transmitter; controlled by single-byte commands.
module tx_frame_scheduler #(
    parameter int unsigned PERIOD_UNIT = 5000000,
    parameter int unsigned ADC_TIMEOUT = 4096,
    parameter logic [7:0]  HEADER      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic       ad_start,
    input  logic       ad_done,
    input  logic [7:0] ad_sample,
    output logic       tx_en_sig,
    output logic [7:0] tx_data,
    input  logic       tx_done_sig,
    input  logic       rx_done_sig,
    input  logic [7:0] rx_data,
    output logic       running,
    output logic       busy,
    output logic       overrun,
    output logic       adc_err
);

    localparam int unsigned ToW     = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
    localparam logic [ToW-1:0] ToLast = ToW'(ADC_TIMEOUT - 1);
    localparam logic [31:0] RstLoad   = 32'(5 * PERIOD_UNIT - 1);

    typedef enum logic [2:0] {StIdle, StConv, StLoad, StSend, StGap} state_t;

    state_t         state_q, state_d;
    logic           ad_start_q, ad_start_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic [7:0]     sample_q, sample_d;
    logic [7:0]     seq_q, seq_d;
    logic [1:0]     idx_q, idx_d;
    logic [ToW-1:0] to_q, to_d;
    logic           running_q, running_d;
    logic           overrun_q, overrun_d;
    logic           adc_err_q, adc_err_d;
    logic [3:0]     period_steps_q, period_steps_d;
    logic [31:0]    timer_q, timer_d;

    logic        tick, adc_timeout, is_busy;
    logic        cmd_go, cmd_stop, cmd_clear, cmd_digit;
    logic [31:0] load_val;
    logic [7:0]  chk, frame_byte;

    assign load_val = 32'(period_steps_q) * 32'(PERIOD_UNIT) - 32'd1;
    assign tick     = running_q && (timer_q == '0);
    assign is_busy  = (state_q != StIdle);
    assign chk      = HEADER + sample_q + seq_q;

    assign cmd_go    = rx_done_sig && (rx_data == 8'h47);
    assign cmd_stop  = rx_done_sig && (rx_data == 8'h53);
    assign cmd_clear = rx_done_sig && (rx_data == 8'h43);
    assign cmd_digit = rx_done_sig && (rx_data >= 8'h31) && (rx_data <= 8'h39);

    always_comb begin
        frame_byte = HEADER;
        unique case (idx_q)
            2'd0: frame_byte = HEADER;
            2'd1: frame_byte = sample_q;
            2'd2: frame_byte = seq_q;
            2'd3: frame_byte = chk;
            default: frame_byte = HEADER;
        endcase
    end

    // Timer and command-driven control registers
    always_comb begin
        timer_d        = timer_q;
        running_d      = running_q;
        period_steps_d = period_steps_q;
        overrun_d      = overrun_q;
        adc_err_d      = adc_err_q;

        // Idle timer sits at the load value so a restart always begins a full period
        if (!running_q || (timer_q == '0)) begin
            timer_d = load_val;
        end else begin
            timer_d = timer_q - 32'd1;
        end

        if (cmd_go) begin
            running_d = 1'b1;
        end else if (cmd_stop) begin
            running_d = 1'b0;
        end
        if (cmd_digit) begin
            period_steps_d = rx_data[3:0];
        end

        // Set beats clear when both happen in the same cycle
        if (tick && is_busy) begin
            overrun_d = 1'b1;
        end else if (cmd_clear) begin
            overrun_d = 1'b0;
        end
        if (adc_timeout) begin
            adc_err_d = 1'b1;
        end else if (cmd_clear) begin
            adc_err_d = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        ad_start_d  = 1'b0;
        to_d        = to_q;
        sample_d    = sample_q;
        tx_data_d   = tx_data_q;
        idx_d       = idx_q;
        seq_d       = seq_q;
        adc_timeout = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    ad_start_d = 1'b1;
                    to_d       = '0;
                    state_d    = StConv;
                end
            end
            StConv: begin
                if (ad_done) begin
                    sample_d = ad_sample;
                    state_d  = StLoad;
                end else if (to_q == ToLast) begin
                    sample_d    = 8'hFF;
                    adc_timeout = 1'b1;
                    state_d     = StLoad;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            StLoad: begin
                tx_data_d = frame_byte;
                state_d   = StSend;
            end
            StSend: begin
                if (tx_done_sig) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = StLoad;
                end else begin
                    idx_d   = 2'd0;
                    seq_d   = seq_q + 8'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            ad_start_q     <= 1'b0;
            tx_data_q      <= 8'h00;
            sample_q       <= 8'h00;
            seq_q          <= 8'h00;
            idx_q          <= 2'd0;
            to_q           <= '0;
            running_q      <= 1'b1;
            overrun_q      <= 1'b0;
            adc_err_q      <= 1'b0;
            period_steps_q <= 4'd5;
            timer_q        <= RstLoad;
        end else begin
            state_q        <= state_d;
            ad_start_q     <= ad_start_d;
            tx_data_q      <= tx_data_d;
            sample_q       <= sample_d;
            seq_q          <= seq_d;
            idx_q          <= idx_d;
            to_q           <= to_d;
            running_q      <= running_d;
            overrun_q      <= overrun_d;
            adc_err_q      <= adc_err_d;
            period_steps_q <= period_steps_d;
            timer_q        <= timer_d;
        end
    end

    // Decoded from state so a reset drops the transmit request without waiting for a clock
    assign tx_en_sig = (state_q == StSend);
    assign busy      = is_busy;
    assign ad_start  = ad_start_q;
    assign tx_data   = tx_data_q;
    assign running   = running_q;
    assign overrun   = overrun_q;
    assign adc_err   = adc_err_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler with behavioural ADC and UART responders.
module tb_tx_frame_scheduler;

    localparam int unsigned PU = 10;
    localparam int unsigned TO = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ad_start, ad_done, tx_en_sig, tx_done_sig, rx_done_sig;
    logic       running, busy, overrun, adc_err;
    logic [7:0] ad_sample, tx_data, rx_data;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rel_cyc  = 0;

    int         adc_delay  = 5;
    int         adc_step   = 0;
    logic [7:0] adc_base   = 8'h3C;
    int         uart_delay = 20;

    logic [7:0] byte_q[$];
    int         start_q[$];
    int         rise_q[$];
    int         done_q[$];

    tx_frame_scheduler #(
        .PERIOD_UNIT(PU),
        .ADC_TIMEOUT(TO),
        .HEADER     (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ad_start   (ad_start),
        .ad_done    (ad_done),
        .ad_sample  (ad_sample),
        .tx_en_sig  (tx_en_sig),
        .tx_data    (tx_data),
        .tx_done_sig(tx_done_sig),
        .rx_done_sig(rx_done_sig),
        .rx_data    (rx_data),
        .running    (running),
        .busy       (busy),
        .overrun    (overrun),
        .adc_err    (adc_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // ADC responder: ad_done adc_delay cycles after ad_start; adc_delay==0 never answers
    initial begin
        int acnt;
        int nconv;
        acnt      = 0;
        nconv     = 0;
        ad_done   = 1'b0;
        ad_sample = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            ad_done = 1'b0;
            if (rst) begin
                acnt  = 0;
                nconv = 0;
            end else if (ad_start) begin
                start_q.push_back(cyc);
                ad_sample = 8'(int'(adc_base) + nconv * adc_step);
                nconv     = nconv + 1;
                acnt      = adc_delay;
            end else if (acnt > 0) begin
                acnt = acnt - 1;
                if (acnt == 0) begin
                    ad_done = 1'b1;
                    done_q.push_back(cyc);
                end
            end
        end
    end

    // UART responder: tx_done_sig uart_delay cycles after tx_en_sig rises; logs sent bytes
    initial begin
        int ucnt;
        ucnt        = 0;
        tx_done_sig = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_done_sig = 1'b0;
            if (!tx_en_sig) begin
                ucnt = 0;
            end else begin
                ucnt = ucnt + 1;
                if (ucnt == 1) rise_q.push_back(cyc);
                if (ucnt == uart_delay) begin
                    tx_done_sig = 1'b1;
                    byte_q.push_back(tx_data);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] pop_frame();
        logic [31:0] f;
        logic [7:0]  b;
        f = '0;
        for (int i = 0; i < 4; i++) begin
            if (byte_q.size() > 0) b = byte_q.pop_front();
            else b = 8'hxx;
            f = {f[23:0], b};
        end
        return f;
    endfunction

    task automatic clear_logs();
        byte_q.delete();
        start_q.delete();
        rise_q.delete();
        done_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        clear_logs();
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(posedge clk);
        #3;
        rx_data     = b;
        rx_done_sig = 1'b1;
        @(posedge clk);
        #3 rx_done_sig = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int t = 0; t < budget && byte_q.size() < n; t++) @(posedge clk);
        #2;
    endtask

    task automatic wait_starts(input int n, input int budget);
        for (int t = 0; t < budget && start_q.size() < n; t++) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if ({ad_start, tx_en_sig, running, busy, overrun, adc_err} !== 6'b001000)
            $display("FAIL reset_flags: got %b, need 001000",
                     {ad_start, tx_en_sig, running, busy, overrun, adc_err});
        else n_pass++;
        n_checks++;
        if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h, need 00", tx_data);
        else n_pass++;
    endtask

    task automatic test_basic();
        int d;
        logic [31:0] f;
        adc_delay = 5; adc_base = 8'h3C; adc_step = 0; uart_delay = 20;
        do_reset();
        // Stray handshakes while idle must not start anything
        repeat (5) @(posedge clk);
        #2;
        ad_done     = 1'b1;
        tx_done_sig = 1'b1;
        @(posedge clk);
        #2;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL stray_pulse_idle: busy=%b, need 0", busy);
        else n_pass++;

        wait_bytes(8, 400);
        f = pop_frame();
        n_checks++;
        if (f !== 32'hA53C00E1) $display("FAIL frame0: got %h, need A53C00E1", f);
        else n_pass++;
        f = pop_frame();
        n_checks++;
        if (f !== 32'hA53C01E2) $display("FAIL frame1: got %h, need A53C01E2", f);
        else n_pass++;

        d = (start_q.size() > 0) ? start_q[0] - rel_cyc : -1;
        n_checks++;
        if (d != 50) $display("FAIL first_ad_start: got %0d cycles, need 50", d);
        else n_pass++;

        d = (start_q.size() > 1) ? start_q[1] - start_q[0] : -1;
        n_checks++;
        if (d != 100) $display("FAIL start_spacing: got %0d, need 100", d);
        else n_pass++;

        d = (rise_q.size() > 0 && done_q.size() > 0) ? rise_q[0] - done_q[0] : -1;
        n_checks++;
        if (d != 2) $display("FAIL done_to_tx_en: got %0d, need 2", d);
        else n_pass++;

        n_checks++;
        if (overrun !== 1'b1) $display("FAIL basic_overrun: got %b, need 1", overrun);
        else n_pass++;
    endtask

    task automatic test_timeout();
        logic [31:0] f;
        adc_delay = 0; uart_delay = 2;
        do_reset();
        wait_bytes(4, 300);
        f = pop_frame();
        n_checks++;
        if (f !== 32'hA5FF00A4) $display("FAIL timeout_frame: got %h, need A5FF00A4", f);
        else n_pass++;
        n_checks++;
        if (adc_err !== 1'b1) $display("FAIL adc_err_set: got %b, need 1", adc_err);
        else n_pass++;
        send_cmd(8'h53);
        for (int t = 0; t < 300 && busy; t++) @(posedge clk);
        #2;
        n_checks++;
        if (overrun !== 1'b1) $display("FAIL timeout_overrun: got %b, need 1", overrun);
        else n_pass++;
        send_cmd(8'h43);
        n_checks++;
        if ({overrun, adc_err} !== 2'b00)
            $display("FAIL clear_cmd: got %b, need 00", {overrun, adc_err});
        else n_pass++;
    endtask

    task automatic test_overrun();
        logic [31:0] f;
        int d;
        adc_delay = 5; adc_base = 8'h3C; uart_delay = 40;
        do_reset();
        wait_bytes(12, 800);
        for (int k = 0; k < 3; k++) begin
            f = pop_frame();
            n_checks++;
            if (f !== {8'hA5, 8'h3C, 8'(k), 8'(8'hE1 + k)})
                $display("FAIL overrun_frame%0d: got %h, need %h", k, f,
                         {8'hA5, 8'h3C, 8'(k), 8'(8'hE1 + k)});
            else n_pass++;
        end
        n_checks++;
        if (start_q.size() != 3) $display("FAIL one_frame_per_tick: got %0d starts, need 3",
                                          start_q.size());
        else n_pass++;
        d = (start_q.size() > 1) ? start_q[1] - start_q[0] : -1;
        n_checks++;
        if (d != 200) $display("FAIL overrun_spacing: got %0d, need 200", d);
        else n_pass++;
        n_checks++;
        if (overrun !== 1'b1) $display("FAIL overrun_flag: got %b, need 1", overrun);
        else n_pass++;
    endtask

    task automatic test_stop_go();
        logic [31:0] f;
        int n0;
        int s1, s2, s3;
        adc_delay = 5; adc_base = 8'h3C; uart_delay = 20;
        do_reset();
        for (int t = 0; t < 200 && rise_q.size() < 2; t++) @(posedge clk);
        send_cmd(8'h53);
        wait_bytes(4, 200);
        f = pop_frame();
        n_checks++;
        if (f !== 32'hA53C00E1) $display("FAIL stop_frame: got %h, need A53C00E1", f);
        else n_pass++;
        n_checks++;
        if (running !== 1'b0) $display("FAIL stop_running: got %b, need 0", running);
        else n_pass++;
        n0 = start_q.size();
        repeat (150) @(posedge clk);
        #2;
        n_checks++;
        if (start_q.size() != 1) $display("FAIL stopped_no_start: got %0d starts, need 1",
                                          start_q.size());
        else n_pass++;

        adc_delay = 1; uart_delay = 1;
        send_cmd(8'h47);
        wait_starts(n0 + 1, 80);
        send_cmd(8'h32);
        wait_starts(n0 + 4, 200);
        s1 = (start_q.size() >= n0 + 2) ? start_q[n0 + 1] - start_q[n0] : -1;
        s2 = (start_q.size() >= n0 + 3) ? start_q[n0 + 2] - start_q[n0 + 1] : -1;
        s3 = (start_q.size() >= n0 + 4) ? start_q[n0 + 3] - start_q[n0 + 2] : -1;
        n_checks++;
        if (s1 != 50) $display("FAIL go_spacing_before_reload: got %0d, need 50", s1);
        else n_pass++;
        n_checks++;
        if (s2 != 20 || s3 != 20)
            $display("FAIL period2_spacing: got %0d,%0d, need 20,20", s2, s3);
        else n_pass++;
    endtask

    task automatic test_reset_mid_send();
        logic [31:0] f;
        adc_delay = 5; adc_base = 8'h3C; uart_delay = 20;
        do_reset();
        for (int t = 0; t < 400 && rise_q.size() < 5; t++) @(posedge clk);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({tx_en_sig, busy} !== 2'b00)
            $display("FAIL async_reset: tx_en/busy got %b, need 00", {tx_en_sig, busy});
        else n_pass++;
        clear_logs();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        wait_bytes(4, 300);
        f = pop_frame();
        n_checks++;
        if (f !== 32'hA53C00E1) $display("FAIL post_reset_frame: got %h, need A53C00E1", f);
        else n_pass++;
    endtask

    task automatic test_seq_wrap();
        logic [31:0] f, e;
        logic [7:0]  s, q;
        adc_delay = 1; uart_delay = 1; adc_base = 8'h10; adc_step = 7;
        do_reset();
        send_cmd(8'h32);
        wait_bytes(257 * 4, 6000);
        for (int k = 0; k < 257; k++) begin
            s = 8'(16 + 7 * k);
            q = 8'(k);
            e = {8'hA5, s, q, 8'(8'hA5 + s + q)};
            f = pop_frame();
            n_checks++;
            if (f !== e) $display("FAIL wrap_frame%0d: got %h, need %h", k, f, e);
            else n_pass++;
        end
    endtask

    initial begin
        rx_done_sig = 1'b0;
        rx_data     = 8'h00;
        test_reset();
        test_basic();
        test_timeout();
        test_overrun();
        test_stop_go();
        test_reset_mid_send();
        test_seq_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
